// File: rtl/prio_enc_pkg.sv
// Shared constants for the priority encoder slice.
// The round-robin search is enabled with PRIO_ENC_ROUND_ROBIN_EN.
package prio_enc_pkg;

   localparam int ERR_CNT_W = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/prio_pick.sv
// Combinational downward search for the first set request bit,
// starting at 'start' and wrapping from 0 back to N-1.
module prio_pick #(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         found
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cand;

   // Walk every position once, keeping the first hit; idx stays 0 when nothing is set
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = start;
      for (int i = 0; i < N; i++) begin
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
         cand = (cand == '0) ? LAST : cand - W'(1);
      end
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with valid/ready handshakes and error counter.
// Define PRIO_ENC_ROUND_ROBIN_EN for rotating priority; otherwise highest index wins.
module prio_encoder_rr
   import prio_enc_pkg::*;
#(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         req,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         idx,
   output logic                 zero,
   output logic                 multi,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] start;
   logic [W-1:0] pickIdx;
   logic         pickFound;
   logic         inXfer;
   logic         reqZero;
   logic         reqMulti;

   assign in_ready = !out_valid || out_ready;
   assign inXfer   = in_valid && in_ready;
   assign reqZero  = (req == '0);
   assign reqMulti = |(req & (req - N'(1)));

   prio_pick #(.N(N)) u_pick (
      .req   (req),
      .start (start),
      .idx   (pickIdx),
      .found (pickFound)
   );

`ifdef PRIO_ENC_ROUND_ROBIN_EN
   logic [W-1:0] ptr;

   assign start = ptr;

   // The winner becomes the lowest priority for the next search
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= LAST;
      end else if (inXfer && pickFound) begin
         ptr <= (pickIdx == '0) ? LAST : pickIdx - W'(1);
      end
   end
`else
   assign start = LAST;
`endif

   // Single output register: load on input transfer, drain on output transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         idx       <= '0;
         zero      <= 1'b0;
         multi     <= 1'b0;
      end else if (inXfer) begin
         out_valid <= 1'b1;
         idx       <= pickIdx;
         zero      <= reqZero;
         multi     <= reqMulti;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Counts malformed (zero or multi-hot) vectors, sticking at the maximum
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (inXfer && (reqZero || reqMulti) && (err_cnt != ERR_CNT_MAX)) begin
         err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr against a cycle-level reference model.
// Follows PRIO_ENC_ROUND_ROBIN_EN so the model matches whichever build is compiled.
module tb_prio_encoder_rr;

   localparam int N = 8;
   localparam int W = $clog2(N);

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] req = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] idx;
   logic         zero;
   logic         multi;
   logic [7:0]   err_cnt;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model state, updated once per clock
   logic mValid;
   int   mIdx;
   logic mZero;
   logic mMulti;
   int   mErr;
   int   mPtr;

   prio_encoder_rr #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .req       (req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .idx       (idx),
      .zero      (zero),
      .multi     (multi),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Winner chosen from the priority rules rather than from any circuit structure
   function automatic int pickWinner(input logic [N-1:0] r, input int ptr);
      int win;
      win = -1;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      for (int s = 0; s < N; s++) begin
         int k;
         k = (ptr - s + N) % N;
         if (win < 0 && r[k]) win = k;
      end
`else
      for (int k = N - 1; k >= 0; k--) begin
         if (win < 0 && r[k]) win = k;
      end
`endif
      return win;
   endfunction

   task automatic checkAll(input string tag);
      checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(mValid));
      checkOutput({tag, ".idx"}, 64'(idx), 64'(mIdx));
      checkOutput({tag, ".zero"}, 64'(zero), 64'(mZero));
      checkOutput({tag, ".multi"}, 64'(multi), 64'(mMulti));
      checkOutput({tag, ".err_cnt"}, 64'(err_cnt), 64'(mErr));
   endtask

   // Drives one cycle of inputs, advances the model and checks the registered outputs
   task automatic applyStimulus(input string tag, input logic v, input logic [N-1:0] r,
                                input logic oRdy, input logic doRst);
      logic xfer;
      int   cnt;
      int   win;
      in_valid  = v;
      req       = r;
      out_ready = oRdy;
      rst       = doRst;
      #1;
      if (!doRst) checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(!mValid || oRdy));
      xfer = v && (!mValid || oRdy);
      if (doRst) begin
         mValid = 1'b0; mIdx = 0; mZero = 1'b0; mMulti = 1'b0; mErr = 0; mPtr = N - 1;
      end else if (xfer) begin
         cnt    = $countones(r);
         win    = pickWinner(r, mPtr);
         mValid = 1'b1;
         mIdx   = (win < 0) ? 0 : win;
         mZero  = (cnt == 0);
         mMulti = (cnt >= 2);
         if (cnt != 1 && mErr < 255) mErr++;
         if (win >= 0) mPtr = (win + N - 1) % N;
      end else if (oRdy) begin
         mValid = 1'b0;
      end
      @(posedge clk);
      #1;
      checkAll(tag);
   endtask

   initial begin
      logic [N-1:0] r;
      mValid = 1'b0; mIdx = 0; mZero = 1'b0; mMulti = 1'b0; mErr = 0; mPtr = N - 1;

      applyStimulus("reset0", 1'b1, 8'hFF, 1'b1, 1'b1);
      applyStimulus("reset1", 1'b0, 8'h00, 1'b1, 1'b1);
      #1;
      checkOutput("postreset.in_ready", 64'(in_ready), 64'(1));

      applyStimulus("onehot", 1'b1, 8'b0000_0100, 1'b1, 1'b0);
      applyStimulus("multi", 1'b1, 8'b1001_0000, 1'b1, 1'b0);
      applyStimulus("allzero", 1'b1, 8'b0000_0000, 1'b1, 1'b0);
      applyStimulus("drain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Backpressure: result must hold and new requests be refused
      applyStimulus("bp.load", 1'b1, 8'b0010_0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus("bp.hold", 1'b1, 8'b0000_0011, 1'b0, 1'b0);
      applyStimulus("bp.swap", 1'b1, 8'b0000_1000, 1'b1, 1'b0);
      applyStimulus("bp.drain", 1'b0, 8'h00, 1'b1, 1'b0);

      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 3))
            0: r = '0;
            1: r = N'(1) << $urandom_range(0, N - 1);
            default: r = N'($urandom);
         endcase
         applyStimulus("rand", 1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 3) != 0), 1'b0);
      end

      for (int i = 0; i < 300; i++) begin
         r = N'($urandom);
         r[0] = 1'b1;
         r[N-1] = 1'b1;
         applyStimulus("sat", 1'b1, r, 1'b1, 1'b0);
      end
      checkOutput("sat.err_cnt", 64'(err_cnt), 64'(255));

      applyStimulus("rr.reset", 1'b0, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus("rr.ff", 1'b1, 8'hFF, 1'b1, 1'b0);

      // Reset with a pending result after a pick that leaves the pointer at 3
      applyStimulus("rst.prep", 1'b0, 8'h00, 1'b1, 1'b1);
      applyStimulus("rst.win4", 1'b1, 8'h10, 1'b0, 1'b0);
      applyStimulus("rst.hit", 1'b1, 8'hFF, 1'b1, 1'b1);
      applyStimulus("rst.after", 1'b1, 8'hFF, 1'b1, 1'b0);
      checkOutput("rst.after.idx7", 64'(idx), 64'(7));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 SHALL have parameter N, default 8, number of request inputs (legal 2..64).
REQ-002 SHALL have derived localparam W = $clog2(N), default 3, index width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  req vector presented.
REQ-006 SHALL have port in_ready  output  1  block accepts req this cycle.
REQ-007 SHALL have port req  input  N  request vector, any number of bits set.
REQ-008 SHALL have port out_valid  output  1  encoded result held.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port idx  output  W  encoded index of winning bit.
REQ-011 SHALL have port zero  output  1  accepted req was all-zero.
REQ-012 SHALL have port multi  output  1  accepted req had more than one bit set.
REQ-013 SHALL have port err_cnt  output  8  saturating count of accepted zero or multi vectors.

Function
REQ-014 SHALL accept a vector when in_valid && in_ready (input transfer).
REQ-015 SHALL drive in_ready = !out_valid || out_ready (single output register, no bubble on continuous flow).
REQ-016 SHALL present the result of an input transfer on out_valid/idx/zero/multi in the following cycle (latency 1).
REQ-017 SHALL hold idx, zero, multi and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid after an output transfer with no simultaneous input transfer.
REQ-019 SHALL, on simultaneous output and input transfer, load the new result and keep out_valid high.
REQ-020 SHALL in fixed-priority mode select the highest-index set bit (req=4'b0110 -> idx=2).
REQ-021 SHALL for all-zero req output idx=0, zero=1, multi=0.
REQ-022 SHALL set multi=1 iff popcount(req) >= 2; exactly one-hot gives zero=0, multi=0.
REQ-023 SHALL increment err_cnt on each input transfer with zero or multi, saturating at 255 with no wrap.
REQ-024 SHALL ignore req while in_valid=0 or in_ready=0.

Reset
REQ-025 SHALL on rst force out_valid=0, idx=0, zero=0, multi=0, err_cnt=0, pointer=N-1.
REQ-026 SHALL have rst take priority over any same-cycle transfer; a pending result is discarded.
REQ-027 SHALL hold in_ready=1 during and after reset (out_valid=0).

Configuration
REQ-028 SHALL use macro PRIO_ENC_ROUND_ROBIN_EN.
REQ-029 SHALL, with the macro defined, search downward from pointer ptr with wrap from 0 to N-1; winner k updates ptr to (k-1) mod N, making k lowest priority next.
REQ-030 SHALL, with the macro defined, leave ptr unchanged on all-zero req and on cycles with no input transfer.
REQ-031 SHALL, without the macro, implement fixed priority (REQ-020) with no pointer register.

Structure
REQ-032 SHALL place ERR_CNT_W=8 and ERR_CNT_MAX=255 in package prio_enc_pkg.
REQ-033 SHALL implement the masked downward search in combinational sub-module prio_pick (inputs req, start; output idx, found).
REQ-034 SHALL instantiate prio_pick with start=N-1 when PRIO_ENC_ROUND_ROBIN_EN is not defined.

Verification
REQ-035 SHALL cover: N=8 fixed, req=8'b0000_0100 -> idx=2, zero=0, multi=0 one cycle later.
REQ-036 SHALL cover: req=8'b1001_0000 -> idx=7, multi=1, err_cnt 0->1; req=0 -> idx=0, zero=1, err_cnt 1->2.
REQ-037 SHALL cover: out_ready=0 for 3 cycles after transfer -> in_ready=0, outputs stable; out_ready=1 with in_valid=1 -> new result next cycle, out_valid stays 1.
REQ-038 SHALL cover: 300 multi-hot transfers -> err_cnt=255, no wrap.
REQ-039 SHALL cover with RR: req=8'hFF repeated 9 times -> idx 7,6,5,4,3,2,1,0,7.
REQ-040 SHALL cover: rst asserted while out_valid=1 and RR ptr=3 -> next cycle out_valid=0, err_cnt=0, ptr=7.
